// File: rtl/bcd_alu_seq.sv
// Sequential signed-magnitude BCD adder/subtractor that handles one digit per cycle, least significant digit first.
// Latency from capture to out_valid: DIGITS cycles normally, 2*DIGITS if the result must be ten's-complemented, 1 cycle on an invalid digit.
// Backpressure: in_ready is high only in IDLE. The result is held with out_valid until out_ready is high.
// Ports: clk, rst_n (async, active-low); a/b/a_sign/b_sign/op with in_valid/in_ready;
//        res/res_sign/ovf/err with out_valid/out_ready.
// Optional macro BCD_ALU_SAT_EN: an add-path overflow saturates res to all nines instead of wrapping.
module bcd_alu_seq #(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [4*DIGITS-1:0] a,
    input  logic [4*DIGITS-1:0] b,
    input  logic                a_sign,
    input  logic                b_sign,
    input  logic                op,
    input  logic                in_valid,
    output logic                in_ready,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4*DIGITS-1:0] res,
    output logic                res_sign,
    output logic                ovf,
    output logic                err
);

    localparam int W = 4 * DIGITS;

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   a_sh, b_sh, work, work_next, res_q, res_final;
    logic           a_sign_q, sub_q, bad_q, carry_q;
    logic           res_sign_q, ovf_q, err_q;
    logic [3:0]     cnt_q;
    logic           bad_digit, last;
    logic [3:0]     dx, dy, dig;
    logic           dsub, cout;
    logic [4:0]     s5, t5;

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign res       = res_q;
    assign res_sign  = res_sign_q;
    assign ovf       = ovf_q;
    assign err       = err_q;

    always_comb begin
        bad_digit = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) bad_digit = 1'b1;
        end
    end

    // One decimal digit step. FIX reuses the subtract path as 0 - digit - borrow,
    // which ten's-complements the working result one digit at a time.
    always_comb begin
        dx   = a_sh[3:0];
        dy   = b_sh[3:0];
        dsub = sub_q;
        if (state_q == FIX) begin
            dx   = 4'd0;
            dy   = work[3:0];
            dsub = 1'b1;
        end
        if (dsub) begin
            s5   = {1'b0, dx} - {1'b0, dy} - {4'b0, carry_q};
            t5   = s5 + 5'd10;
            cout = s5[4];
            dig  = s5[4] ? t5[3:0] : s5[3:0];
        end else begin
            s5   = {1'b0, dx} + {1'b0, dy} + {4'b0, carry_q};
            t5   = s5 - 5'd10;
            cout = (s5 > 5'd9);
            dig  = cout ? t5[3:0] : s5[3:0];
        end
    end

    // Each new digit enters at the top, so after DIGITS steps the LSD sits in the bottom nibble.
    assign work_next = (work >> 4) | (W'(dig) << (W - 4));
    assign last      = (cnt_q == 4'(DIGITS - 1));

    always_comb begin
        res_final = work_next;
`ifdef BCD_ALU_SAT_EN
        if (!sub_q && cout) res_final = {DIGITS{4'h9}};
`endif
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (in_valid) state_d = RUN;
            RUN: begin
                if (bad_q)                    state_d = DONE;
                else if (last && sub_q && cout) state_d = FIX;
                else if (last)                state_d = DONE;
            end
            FIX:  if (last) state_d = DONE;
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh <= '0; b_sh <= '0; work <= '0; res_q <= '0;
            a_sign_q <= 1'b0; sub_q <= 1'b0; bad_q <= 1'b0; carry_q <= 1'b0;
            res_sign_q <= 1'b0; ovf_q <= 1'b0; err_q <= 1'b0; cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    a_sh     <= a;
                    b_sh     <= b;
                    a_sign_q <= a_sign;
                    sub_q    <= ~op ^ a_sign ^ b_sign;
                    bad_q    <= bad_digit;
                    carry_q  <= 1'b0;
                    cnt_q    <= '0;
                    work     <= '0;
                end
                RUN: begin
                    if (bad_q) begin
                        res_q <= '0; res_sign_q <= 1'b0; ovf_q <= 1'b0; err_q <= 1'b1;
                    end else begin
                        a_sh    <= a_sh >> 4;
                        b_sh    <= b_sh >> 4;
                        work    <= work_next;
                        carry_q <= cout;
                        cnt_q   <= cnt_q + 4'd1;
                        if (last) begin
                            if (sub_q && cout) begin
                                // |a| < |b|: restart the digit walk for the complement pass.
                                cnt_q   <= '0;
                                carry_q <= 1'b0;
                            end else begin
                                res_q      <= res_final;
                                res_sign_q <= (res_final != '0) ? a_sign_q : 1'b0;
                                ovf_q      <= ~sub_q & cout;
                                err_q      <= 1'b0;
                            end
                        end
                    end
                end
                FIX: begin
                    work    <= work_next;
                    carry_q <= cout;
                    cnt_q   <= cnt_q + 4'd1;
                    if (last) begin
                        // A complemented result is never zero, so the sign flip is always legal.
                        res_q      <= work_next;
                        res_sign_q <= ~a_sign_q;
                        ovf_q      <= 1'b0;
                        err_q      <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_alu_seq.sv
module tb_bcd_alu_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] a = '0, b = '0;
    logic        a_sign = 1'b0, b_sign = 1'b0, op = 1'b0;
    logic        in_valid = 1'b0, out_ready = 1'b0;
    logic        in_ready, out_valid, res_sign, ovf, err;
    logic [15:0] res;

    int total = 0;
    int passed = 0;

    bcd_alu_seq #(.DIGITS(4)) dut (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .a_sign(a_sign), .b_sign(b_sign),
        .op(op), .in_valid(in_valid), .in_ready(in_ready), .out_valid(out_valid),
        .out_ready(out_ready), .res(res), .res_sign(res_sign), .ovf(ovf), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a, b;
        logic        as, bs, op;
        logic [15:0] res;
        logic        sign, ovf, err;
        int          lat;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", name, got, exp);
        else passed++;
    endtask

    function automatic int bcd2int(input logic [15:0] v);
        int r = 0;
        for (int i = 3; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [15:0] int2bcd(input int v);
        logic [15:0] r = '0;
        int x = v;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Reference model: signed-magnitude decimal arithmetic on plain integers.
    function automatic vec_t model(input logic [15:0] ia, ib, input logic ias, ibs, iop);
        vec_t e;
        int ma, mb, sa, sb, r;
        logic bad = 1'b0;
        e.a = ia; e.b = ib; e.as = ias; e.bs = ibs; e.op = iop;
        for (int i = 0; i < 4; i++)
            if (ia[4*i +: 4] > 9 || ib[4*i +: 4] > 9) bad = 1'b1;
        if (bad) begin
            e.res = '0; e.sign = 0; e.ovf = 0; e.err = 1; e.lat = 1;
            return e;
        end
        ma = bcd2int(ia); mb = bcd2int(ib);
        sa = ias ? -ma : ma;
        sb = ibs ? -mb : mb;
        e.err = 0; e.ovf = 0;
        if ((ias ^ ibs) == iop) begin
            // Signed operands have opposite effective signs, so magnitudes are subtracted.
            r = iop ? sa + sb : sa - sb;
            e.lat = ((r < 0) != ias && r != 0) ? 8 : 4;
            e.res = int2bcd(r < 0 ? -r : r);
            e.sign = (r < 0);
        end else begin
            r = ma + mb;
            e.ovf = (r >= 10000);
`ifdef BCD_ALU_SAT_EN
            if (e.ovf) r = 9999;
`endif
            r = r % 10000;
            e.res = int2bcd(r);
            e.sign = (r != 0) ? ias : 1'b0;
            e.lat = 4;
        end
        return e;
    endfunction

    task automatic start_op(input logic [15:0] ia, ib, input logic ias, ibs, iop, output int lat);
        @(negedge clk);
        a = ia; b = ib; a_sign = ias; b_sign = ibs; op = iop; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic release_out();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic run_check(input string tag, input vec_t v);
        int lat;
        start_op(v.a, v.b, v.as, v.bs, v.op, lat);
        chk({tag, ".lat"}, lat, v.lat);
        chk({tag, ".res"}, res, v.res);
        chk({tag, ".sign"}, res_sign, v.sign);
        chk({tag, ".ovf"}, ovf, v.ovf);
        chk({tag, ".err"}, err, v.err);
        release_out();
    endtask

    initial begin
        vec_t tbl[8];
        vec_t e;
        int lat, seen;
        logic [15:0] ra, rb, held;

        tbl[0] = '{16'h0010, 16'h0015, 0, 0, 1, 16'h0025, 0, 0, 0, 4};
`ifdef BCD_ALU_SAT_EN
        tbl[1] = '{16'h9876, 16'h0200, 0, 0, 1, 16'h9999, 0, 1, 0, 4};
        tbl[5] = '{16'h5000, 16'h5000, 1, 1, 1, 16'h9999, 1, 1, 0, 4};
`else
        tbl[1] = '{16'h9876, 16'h0200, 0, 0, 1, 16'h0076, 0, 1, 0, 4};
        tbl[5] = '{16'h5000, 16'h5000, 1, 1, 1, 16'h0000, 0, 1, 0, 4};
`endif
        tbl[2] = '{16'h0003, 16'h0008, 0, 0, 0, 16'h0005, 1, 0, 0, 8};
        tbl[3] = '{16'h0005, 16'h0005, 1, 1, 0, 16'h0000, 0, 0, 0, 4};
        tbl[4] = '{16'h00A1, 16'h0005, 0, 0, 1, 16'h0000, 0, 0, 1, 1};
        tbl[6] = '{16'h0100, 16'h0250, 1, 0, 1, 16'h0150, 0, 0, 0, 8};
        tbl[7] = '{16'h1234, 16'h00F0, 0, 1, 0, 16'h0000, 0, 0, 1, 1};

        #12;
        chk("rst.in_ready", in_ready, 1);
        chk("rst.out_valid", out_valid, 0);
        chk("rst.res", res, 0);
        chk("rst.flags", {res_sign, ovf, err}, 0);
        @(negedge clk) rst_n = 1'b1;

        foreach (tbl[i]) run_check($sformatf("vec%0d", i), tbl[i]);

        // Reset aborts an operation in RUN; a non-zero result is held beforehand.
        run_check("pre_abort", tbl[0]);
        @(negedge clk);
        a = 16'h0003; b = 16'h0008; a_sign = 0; b_sign = 0; op = 0; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort.res", res, 0);
        chk("abort.out_valid", out_valid, 0);
        chk("abort.in_ready", in_ready, 1);
        @(negedge clk) rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1 if (out_valid) seen++;
        end
        chk("abort.no_valid", seen, 0);
        run_check("after_abort", '{16'h1234, 16'h0001, 0, 0, 1, 16'h1235, 0, 0, 0, 4});

        // Backpressure in DONE with in_valid held high.
        start_op(16'h0010, 16'h0015, 0, 0, 1, lat);
        chk("bp.lat", lat, 4);
        held = res;
        @(negedge clk);
        a = 16'h4444; b = 16'h1111; in_valid = 1'b1;
        seen = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1 if (!out_valid || res !== 16'h0025 || in_ready) seen++;
        end
        chk("bp.stable", seen, 0);
        chk("bp.held", held, 16'h0025);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        chk("bp.in_ready", in_ready, 1);
        chk("bp.out_valid", out_valid, 0);

        for (int n = 0; n < 200; n++) begin
            for (int d = 0; d < 4; d++) begin
                ra[4*d +: 4] = 4'($urandom_range(0, 9));
                rb[4*d +: 4] = 4'($urandom_range(0, 9));
            end
            if ($urandom_range(0, 15) == 0) ra[4*$urandom_range(0, 3) +: 4] = 4'($urandom_range(10, 15));
            if ($urandom_range(0, 3) == 0) rb = rb >> 8;
            e = model(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            run_check($sformatf("rnd%0d", n), e);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
